map_compositor: RTL and testbench



---
 rtl/map_compositor.sv | 170 +++++++++++++++++
 tb/tb_map_compositor.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_compositor.sv
// map_compositor: selects one of NUM_ROOMS room pixel streams by matching
// (mapX, mapY) against a per-room coordinate table. Room switches are
// latched only on the VBlank rising edge and may be followed by FADE_FRAMES
// black frames. The pixel path is PIPE_STAGES registers deep.
//
// Optional build macro: MAP_COMPOSITOR_TESTPAT_EN
//   Adds the testPattern input. When it is high, the room colour is replaced
//   by three horizontal colour bands, and fade and room validity are ignored.
module map_compositor #(
    parameter int NUM_ROOMS   = 8,
    parameter int COLOR_W     = 8,
    parameter int COORD_W     = 4,
    parameter int PIPE_STAGES = 1,
    parameter int FADE_FRAMES = 2
) (
    input  logic                           clk_vga,
    input  logic                           reset,
    input  logic [9:0]                     CurrentX,
    input  logic [8:0]                     CurrentY,
    input  logic                           HBlank,
    input  logic                           VBlank,
    input  logic [COORD_W-1:0]             mapX,
    input  logic [COORD_W-1:0]             mapY,
    input  logic [NUM_ROOMS*COLOR_W-1:0]   roomData,
    input  logic [NUM_ROOMS*2*COORD_W-1:0] roomCoord,
`ifdef MAP_COMPOSITOR_TESTPAT_EN
    input  logic                           testPattern,
`endif
    output logic [COLOR_W-1:0]             mapData,
    output logic [3:0]                     roomIndex,
    output logic                           roomValid,
    output logic                           roomChanged
);

    typedef enum logic {
        SHOW = 1'b0,
        FADE = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  fade_cnt;
    logic [3:0]  fade_next;
    logic        vblank_d;
    logic        vsync_edge;
    logic        room_change;

    logic        hit;
    logic [3:0]  idx;

    logic [COLOR_W-1:0]     room_pix;
    logic [COLOR_W-1:0]     s1_color;
    logic                   s1_kill;
    logic [COLOR_W-1:0]     color_pipe [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] kill_pipe;

    // Coordinate lookup: scan from the top so the lowest matching index wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        hit = 1'b0;
        idx = 4'd0;
        for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
            if (roomCoord[i*2*COORD_W +: 2*COORD_W] == {mapY, mapX}) begin
                hit = 1'b1;
                idx = 4'(i);
            end
        end
    end

    assign vsync_edge  = VBlank & ~vblank_d;
    assign room_change = vsync_edge && ({hit, idx} != {roomValid, roomIndex});
    assign fade_next   = fade_cnt + 4'd1;

    // Frame-boundary room latch and SHOW/FADE sequencing.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            state       <= SHOW;
            fade_cnt    <= 4'd0;
            vblank_d    <= 1'b0;
            roomIndex   <= 4'd0;
            roomValid   <= 1'b0;
            roomChanged <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values of its neighbours, independent of order.
            vblank_d    <= VBlank;
            roomChanged <= room_change;
            if (room_change) begin
                roomValid <= hit;
                roomIndex <= idx;
                if (FADE_FRAMES > 0) begin
                    state    <= FADE;
                    fade_cnt <= 4'd0;
                end
            end else if (vsync_edge && state == FADE) begin
                fade_cnt <= fade_next;
                if (fade_next == 4'(FADE_FRAMES)) begin
                    state <= SHOW;
                end
            end
        end
    end

    // Active room colour mux; indices outside the table select nothing.
    always_comb begin
        room_pix = '0;
        for (int i = 0; i < NUM_ROOMS; i++) begin
            if (roomIndex == 4'(i)) begin
                room_pix = roomData[i*COLOR_W +: COLOR_W];
            end
        end
    end

`ifdef MAP_COMPOSITOR_TESTPAT_EN
    logic [COLOR_W-1:0] band_color;
    logic               unused;

    // Three horizontal test bands selected by the current row.
    always_comb begin
        if (CurrentY < 9'd160) begin
            band_color = COLOR_W'(8'hE0);
        end else if (CurrentY < 9'd320) begin
            band_color = COLOR_W'(8'h1C);
        end else begin
            band_color = COLOR_W'(8'h03);
        end
    end

    // Test pattern overrides the room colour; only blanking can blacken it.
    always_comb begin
        s1_color = testPattern ? band_color : room_pix;
        s1_kill  = HBlank | VBlank |
                   (~testPattern & (~roomValid | (state == FADE)));
    end

    assign unused = ^CurrentX;
`else
    logic unused;

    // Stage-1 colour and blackout decision for the normal room path.
    always_comb begin
        s1_color = room_pix;
        s1_kill  = HBlank | VBlank | ~roomValid | (state == FADE);
    end

    assign unused = ^{CurrentX, CurrentY};
`endif

    // Pixel pipeline: stage 1 captures, later stages delay colour and kill.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            // NOTE: this is a short chain of flops rather than a RAM, so it
            // is reset explicitly to guarantee black output after reset.
            for (int s = 0; s < PIPE_STAGES; s++) begin
                color_pipe[s] <= '0;
            end
            kill_pipe <= '0;
        end else begin
            color_pipe[0] <= s1_color;
            kill_pipe[0]  <= s1_kill;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                color_pipe[s] <= color_pipe[s-1];
                kill_pipe[s]  <= kill_pipe[s-1];
            end
        end
    end

    assign mapData = kill_pipe[PIPE_STAGES-1] ? '0 : color_pipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_map_compositor.sv
// Self-checking bench for map_compositor with a miniature raster
// (8 active + 4 HBlank columns, 4 active + 2 VBlank lines). A frame-level
// model tracks the active room and remaining black frames, and a delay line
// of PIPE_STAGES expected pixels gives the required mapData every cycle.
`timescale 1ns/1ps
module tb_map_compositor;

    localparam int N         = 5;
    localparam int CW        = 8;
    localparam int KW        = 4;
    localparam int P         = 3;
    localparam int F         = 2;
    localparam int DW        = N * CW;
    localparam int ACT_W     = 8;
    localparam int LINE_W    = 12;
    localparam int ACT_H     = 4;
    localparam int FRAME_H   = 6;
    localparam int FRAME_CYC = LINE_W * FRAME_H;

    // Fixed room colours: room0=A5, room1=99, room2=42, room3=77, room4=3C.
    localparam logic [DW-1:0] FIXED_DATA = {8'h3C, 8'h77, 8'h42, 8'h99, 8'hA5};

    logic            clk_vga = 1'b0;
    logic            reset = 1'b1;
    logic [9:0]      CurrentX = '0;
    logic [8:0]      CurrentY = '0;
    logic            HBlank = 1'b0;
    logic            VBlank = 1'b0;
    logic [KW-1:0]   mapX = '0;
    logic [KW-1:0]   mapY = '0;
    logic [DW-1:0]   roomData = '0;
    logic [N*2*KW-1:0] roomCoord = '0;
    logic [CW-1:0]   mapData;
    logic [3:0]      roomIndex;
    logic            roomValid;
    logic            roomChanged;
`ifdef MAP_COMPOSITOR_TESTPAT_EN
    logic            testPattern = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int            cx [N] = '{3, 3, 4, 4, 2};
    int            cy [N] = '{5, 6, 6, 7, 6};
    int            m_idx = 0;
    bit            m_valid = 0;
    int            m_fade_left = 0;
    bit            m_changed = 0;
    bit            m_vb_prev = 0;
    logic [CW-1:0] m_pipe [P];
    bit            tp_m = 0;
    bit            rand_data = 1;
    int            pos_line = 0;
    int            pos_col = 0;

    map_compositor #(
        .NUM_ROOMS  (N),
        .COLOR_W    (CW),
        .COORD_W    (KW),
        .PIPE_STAGES(P),
        .FADE_FRAMES(F)
    ) dut (
        .clk_vga    (clk_vga),
        .reset      (reset),
        .CurrentX   (CurrentX),
        .CurrentY   (CurrentY),
        .HBlank     (HBlank),
        .VBlank     (VBlank),
        .mapX       (mapX),
        .mapY       (mapY),
        .roomData   (roomData),
        .roomCoord  (roomCoord),
`ifdef MAP_COMPOSITOR_TESTPAT_EN
        .testPattern(testPattern),
`endif
        .mapData    (mapData),
        .roomIndex  (roomIndex),
        .roomValid  (roomValid),
        .roomChanged(roomChanged)
    );

    always #5 clk_vga = ~clk_vga;

    function automatic logic [CW-1:0] band_of(input logic [8:0] y);
        if (y < 9'd160) return 8'hE0;
        if (y < 9'd320) return 8'h1C;
        return 8'h03;
    endfunction

    task automatic load_table();
        for (int i = 0; i < N; i++) begin
            roomCoord[i*2*KW +: 2*KW] = {4'(cy[i]), 4'(cx[i])};
        end
    endtask

    // Model of one clock edge using the inputs present at that edge.
    function automatic void model_edge();
        logic [CW-1:0] pix;
        bit hit;
        int idx;
        if (reset) begin
            m_idx = 0; m_valid = 0; m_fade_left = 0; m_changed = 0; m_vb_prev = 0;
            for (int s = 0; s < P; s++) m_pipe[s] = '0;
            return;
        end
        pix = '0;
        if (!HBlank && !VBlank) begin
            if (tp_m) pix = band_of(CurrentY);
            else if (m_valid && m_fade_left == 0) pix = roomData[m_idx*CW +: CW];
        end
        for (int s = P - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = pix;
        m_changed = 0;
        if (VBlank && !m_vb_prev) begin
            hit = 0; idx = 0;
            for (int i = 0; i < N; i++) begin
                if (!hit && cx[i] == int'(mapX) && cy[i] == int'(mapY)) begin
                    hit = 1; idx = i;
                end
            end
            if (hit != m_valid || idx != m_idx) begin
                m_valid = hit; m_idx = idx; m_changed = 1; m_fade_left = F;
            end else if (m_fade_left > 0) begin
                m_fade_left--;
            end
        end
        m_vb_prev = VBlank;
    endfunction

    // Drive one raster position, clock it, update the model, advance raster.
    task automatic tick();
        CurrentX = 10'(pos_col);
        CurrentY = (pos_line < ACT_H) ? 9'(pos_line * 100 + 100) : 9'd0;
        HBlank   = (pos_col >= ACT_W);
        VBlank   = (pos_line >= ACT_H);
        if (rand_data) roomData = DW'({$urandom(), $urandom()});
`ifdef MAP_COMPOSITOR_TESTPAT_EN
        testPattern = tp_m;
`endif
        @(posedge clk_vga);
        model_edge();
        #1;
        pos_col++;
        if (pos_col == LINE_W) begin
            pos_col  = 0;
            pos_line = (pos_line + 1) % FRAME_H;
        end
    endtask

    // One frame of clocks; optional mid-frame request change; gathers counts.
    task automatic window(input int switch_at, input int sx, input int sy,
                          input logic [CW-1:0] colour,
                          output int n_colour, output int n_nonzero,
                          output int n_pulse, output int n_bad, output string bad_msg);
        n_colour = 0; n_nonzero = 0; n_pulse = 0; n_bad = 0; bad_msg = "none";
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k == switch_at) begin
                mapX = 4'(sx);
                mapY = 4'(sy);
            end
            tick();
            if (mapData == colour) n_colour++;
            if (mapData != '0) n_nonzero++;
            if (roomChanged) n_pulse++;
            if (mapData !== m_pipe[P-1] ||
                {roomChanged, roomValid, roomIndex} !== {m_changed, m_valid, 4'(m_idx)}) begin
                if (n_bad == 0)
                    bad_msg = $sformatf("cycle %0d mapData=%h want %h chg/val/idx=%b/%b/%0d want %b/%b/%0d",
                                        k, mapData, m_pipe[P-1], roomChanged, roomValid, roomIndex,
                                        m_changed, m_valid, m_idx);
                n_bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rand_data = 1;
        mapX = 4'($urandom_range(0, 15));
        mapY = 4'($urandom_range(0, 15));
        pos_line = ACT_H - 1;
        pos_col  = LINE_W - 3;
        repeat (3) begin
            tick();
            checks++;
            if (mapData !== '0 || roomIndex !== 4'd0 || roomValid !== 1'b0 || roomChanged !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: mapData=%h roomIndex=%0d roomValid=%b roomChanged=%b, required 00/0/0/0",
                         mapData, roomIndex, roomValid, roomChanged);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_first_room();
        int nc, nz, np, nb;
        string msg;
        int exp_nz [3] = '{0, 0, 32};
        int exp_p  [3] = '{1, 0, 0};
        rand_data = 0;
        roomData  = FIXED_DATA;
        mapX = 4'd3; mapY = 4'd5;
        for (int w = 0; w < 3; w++) begin
            window(-1, 0, 0, 8'hA5, nc, nz, np, nb, msg);
            checks++;
            if (nb != 0) begin errors++; $display("FAIL first_room_model w%0d: %0d bad cycles, first %s", w, nb, msg); end
            checks++;
            if (nz != exp_nz[w] || nc != exp_nz[w]) begin
                errors++; $display("FAIL first_room_pixels w%0d: A5 count %0d nonzero %0d, required %0d", w, nc, nz, exp_nz[w]);
            end
            checks++;
            if (np != exp_p[w]) begin errors++; $display("FAIL first_room_pulse w%0d: got %0d required %0d", w, np, exp_p[w]); end
        end
        checks++;
        if (roomIndex !== 4'd0 || roomValid !== 1'b1) begin
            errors++; $display("FAIL first_room_latch: roomIndex=%0d roomValid=%b, required 0/1", roomIndex, roomValid);
        end
    endtask

    task automatic test_midframe_switch();
        int nc, nz, np, nb;
        string msg;
        int            sw     [4] = '{48, -1, -1, -1};
        logic [CW-1:0] col    [4] = '{8'hA5, 8'h42, 8'h42, 8'h42};
        int            exp_nz [4] = '{32, 0, 0, 32};
        int            exp_p  [4] = '{0, 1, 0, 0};
        for (int w = 0; w < 4; w++) begin
            window(sw[w], 4, 6, col[w], nc, nz, np, nb, msg);
            checks++;
            if (nb != 0) begin errors++; $display("FAIL midframe_model w%0d: %0d bad cycles, first %s", w, nb, msg); end
            checks++;
            if (nz != exp_nz[w] || nc != exp_nz[w]) begin
                errors++; $display("FAIL midframe_pixels w%0d: colour %h count %0d nonzero %0d, required %0d", w, col[w], nc, nz, exp_nz[w]);
            end
            checks++;
            if (np != exp_p[w]) begin errors++; $display("FAIL midframe_pulse w%0d: got %0d required %0d", w, np, exp_p[w]); end
        end
        checks++;
        if (roomIndex !== 4'd2 || roomValid !== 1'b1) begin
            errors++; $display("FAIL midframe_latch: roomIndex=%0d roomValid=%b, required 2/1", roomIndex, roomValid);
        end
    endtask

    task automatic test_no_match();
        int nc, nz, np, nb;
        string msg;
        int exp_p [2] = '{1, 0};
        for (int w = 0; w < 2; w++) begin
            window(w == 0 ? 0 : -1, 7, 7, 8'h42, nc, nz, np, nb, msg);
            checks++;
            if (nb != 0) begin errors++; $display("FAIL no_match_model w%0d: %0d bad cycles, first %s", w, nb, msg); end
            checks++;
            if (nz != 0 || np != exp_p[w]) begin
                errors++; $display("FAIL no_match_output w%0d: nonzero %0d pulses %0d, required 0 and %0d", w, nz, np, exp_p[w]);
            end
        end
        checks++;
        if (roomIndex !== 4'd0 || roomValid !== 1'b0) begin
            errors++; $display("FAIL no_match_latch: roomIndex=%0d roomValid=%b, required 0/0", roomIndex, roomValid);
        end
    endtask

    task automatic test_fade_restart();
        int nc, nz, np, nb;
        string msg;
        int exp_nz [4] = '{0, 0, 0, 32};
        int exp_p  [4] = '{1, 1, 0, 0};
        mapX = 4'd3; mapY = 4'd6;
        for (int w = 0; w < 4; w++) begin
            window(w == 0 ? 30 : -1, 4, 7, 8'h77, nc, nz, np, nb, msg);
            checks++;
            if (nb != 0) begin errors++; $display("FAIL fade_restart_model w%0d: %0d bad cycles, first %s", w, nb, msg); end
            checks++;
            if (nz != exp_nz[w] || nc != exp_nz[w]) begin
                errors++; $display("FAIL fade_restart_pixels w%0d: 77 count %0d nonzero %0d, required %0d", w, nc, nz, exp_nz[w]);
            end
            checks++;
            if (np != exp_p[w]) begin errors++; $display("FAIL fade_restart_pulse w%0d: got %0d required %0d", w, np, exp_p[w]); end
        end
        checks++;
        if (roomIndex !== 4'd3) begin errors++; $display("FAIL fade_restart_latch: roomIndex=%0d required 3", roomIndex); end
    endtask

    task automatic test_hblank_latency();
        int l, c;
        for (int k = 0; k < FRAME_CYC; k++) begin
            l = pos_line;
            c = pos_col;
            tick();
            if (l < ACT_H && c == ACT_W + 1) begin
                checks++;
                if (mapData !== 8'h77) begin
                    errors++; $display("FAIL hblank_last_active line %0d: mapData=%h required 77", l, mapData);
                end
            end
            if (l < ACT_H && c == ACT_W + 2) begin
                checks++;
                if (mapData !== 8'h00) begin
                    errors++; $display("FAIL hblank_t_plus_3 line %0d: mapData=%h required 00", l, mapData);
                end
            end
        end
    endtask

    task automatic test_priority();
        int nc, nz, np, nb;
        string msg;
        cx = '{3, 3, 4, 3, 3};
        cy = '{5, 6, 6, 6, 6};
        load_table();
        window(0, 3, 6, 8'h99, nc, nz, np, nb, msg);
        checks++;
        if (nb != 0) begin errors++; $display("FAIL priority_model: %0d bad cycles, first %s", nb, msg); end
        checks++;
        if (roomIndex !== 4'd1 || roomValid !== 1'b1 || np != 1) begin
            errors++; $display("FAIL priority_lowest: roomIndex=%0d roomValid=%b pulses=%0d, required 1/1/1", roomIndex, roomValid, np);
        end
        cx = '{3, 3, 4, 4, 2};
        cy = '{5, 6, 6, 7, 6};
        load_table();
    endtask

    task automatic test_back_to_back();
        int nc, nz, np, nb, t;
        string msg;
        rand_data = 1;
        for (int w = 0; w < 24; w++) begin
            t = $urandom_range(0, 5);
            window($urandom_range(0, FRAME_CYC - 1), t < N ? cx[t] : 7, t < N ? cy[t] : 7,
                   8'h00, nc, nz, np, nb, msg);
            checks++;
            if (nb != 0) begin errors++; $display("FAIL random_model w%0d: %0d bad cycles, first %s", w, nb, msg); end
            if ($urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                repeat (2) tick();
                reset = 1'b0;
                checks++;
                if (mapData !== '0 || roomIndex !== 4'd0 || roomValid !== 1'b0 || roomChanged !== 1'b0) begin
                    errors++; $display("FAIL random_reset w%0d: mapData=%h idx=%0d valid=%b chg=%b, required zeros",
                                       w, mapData, roomIndex, roomValid, roomChanged);
                end
            end
        end
    endtask

`ifdef MAP_COMPOSITOR_TESTPAT_EN
    task automatic test_testpat();
        int l, c;
        logic [CW-1:0] bands [ACT_H] = '{8'hE0, 8'h1C, 8'h1C, 8'h03};
        tp_m = 1;
        rand_data = 1;
        for (int k = 0; k < 2 * FRAME_CYC; k++) begin
            l = pos_line;
            c = pos_col;
            tick();
            if (k >= P && c == ACT_W + 1 && l < ACT_H) begin
                checks++;
                if (mapData !== bands[l]) begin
                    errors++; $display("FAIL testpat_band line %0d: mapData=%h required %h", l, mapData, bands[l]);
                end
            end
            if (k >= P && c == 5 && l >= ACT_H) begin
                checks++;
                if (mapData !== 8'h00) begin
                    errors++; $display("FAIL testpat_vblank line %0d: mapData=%h required 00", l, mapData);
                end
            end
        end
        tp_m = 0;
    endtask
`endif

    initial begin
        for (int s = 0; s < P; s++) m_pipe[s] = '0;
        load_table();
        test_reset();
        test_first_room();
        test_midframe_switch();
        test_no_match();
        test_fade_restart();
        test_hblank_latency();
        test_priority();
        test_back_to_back();
`ifdef MAP_COMPOSITOR_TESTPAT_EN
        test_testpat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
